// File: rtl/dmem_responder_if.sv
// Memory-stage data port: word address, write data and store strobe out, registered read data back.
interface dmem_responder_if;
    logic [11:0] address_dmem;
    logic [31:0] d_dmem;
    logic        wren;
    logic [31:0] q_dmem;

    // No valid/ready pair: every cycle is an access. The address is always read, wren qualifies a store,
    // and q_dmem carries the word addressed at the previous edge.
    modport master (output address_dmem, output d_dmem, output wren, input q_dmem);
    modport slave  (input address_dmem, input d_dmem, input wren, output q_dmem);
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM in the low addresses, MMIO block (LEDs, buttons, timer) in the
// top 16 words. Reads are registered and read-first against a same-cycle store.
module dmem_responder #(
    parameter int NUM_MOLES = 9,
    parameter int RAM_WORDS = 4080
) (
    input  logic                 clock,
    input  logic                 reset,
    dmem_responder_if.slave      bus,
    input  logic [NUM_MOLES-1:0] buttons,
    output logic [NUM_MOLES-1:0] leds,
    output logic                 timer_irq
);

    localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    localparam logic [11:0] ADDR_LED   = 12'hFF0;
    localparam logic [11:0] ADDR_BTN   = 12'hFF1;
    localparam logic [11:0] ADDR_EVENT = 12'hFF2;
    localparam logic [11:0] ADDR_TIMER = 12'hFF3;
    localparam logic [11:0] ADDR_CMP   = 12'hFF4;
    localparam logic [11:0] ADDR_FLAG  = 12'hFF5;

    logic [31:0]          ram [RAM_WORDS];
    logic                 ram_hit;
    logic [AW-1:0]        ram_idx;
    logic [31:0]          rd_data;

    logic [NUM_MOLES-1:0] sync1;
    logic [NUM_MOLES-1:0] sync2;
    logic [NUM_MOLES-1:0] event_reg;
    logic [NUM_MOLES-1:0] event_clr;
    logic [31:0]          timer_reg;
    logic [31:0]          cmp_reg;
    logic                 flag_reg;

    logic wr_led, wr_event, wr_timer, wr_cmp, wr_flag;

    assign ram_hit  = (bus.address_dmem < 12'(RAM_WORDS));
    assign ram_idx  = bus.address_dmem[AW-1:0];

    assign wr_led   = bus.wren && (bus.address_dmem == ADDR_LED);
    assign wr_event = bus.wren && (bus.address_dmem == ADDR_EVENT);
    assign wr_timer = bus.wren && (bus.address_dmem == ADDR_TIMER);
    assign wr_cmp   = bus.wren && (bus.address_dmem == ADDR_CMP);
    assign wr_flag  = bus.wren && (bus.address_dmem == ADDR_FLAG);

    assign event_clr = wr_event ? bus.d_dmem[NUM_MOLES-1:0] : '0;
    assign timer_irq = flag_reg;

    // RAM contents survive reset, so the array sits in its own unreset process.
    always_ff @(posedge clock) begin
        if (bus.wren && ram_hit) begin
            ram[ram_idx] <= bus.d_dmem;
        end
    end

    always_comb begin
        rd_data = 32'h0;
        if (ram_hit) begin
            rd_data = ram[ram_idx];
        end else begin
            unique case (bus.address_dmem)
                ADDR_LED:   rd_data = 32'(leds);
                ADDR_BTN:   rd_data = 32'(sync2);
                ADDR_EVENT: rd_data = 32'(event_reg);
                ADDR_TIMER: rd_data = timer_reg;
                ADDR_CMP:   rd_data = cmp_reg;
                ADDR_FLAG:  rd_data = {31'h0, flag_reg};
                default:    rd_data = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.q_dmem <= 32'h0;
            leds       <= '0;
            sync1      <= '0;
            sync2      <= '0;
            event_reg  <= '0;
            timer_reg  <= 32'h0;
            cmp_reg    <= 32'hFFFF_FFFF;
            flag_reg   <= 1'b0;
        end else begin
            bus.q_dmem <= rd_data;
            sync1      <= buttons;
            sync2      <= sync1;
            if (wr_led) begin
                leds <= bus.d_dmem[NUM_MOLES-1:0];
            end
            // A fresh edge wins over a simultaneous write-one-to-clear.
            event_reg <= (event_reg & ~event_clr) | (sync1 & ~sync2);
            timer_reg <= wr_timer ? bus.d_dmem : timer_reg + 32'd1;
            if (wr_cmp) begin
                cmp_reg <= bus.d_dmem;
            end
            flag_reg <= (timer_reg == cmp_reg) | (flag_reg & ~(wr_flag & bus.d_dmem[0]));
        end
    end

endmodule
